// File: rtl/zy_net.sv
// Single-layer fixed-point MAC classifier: AXI4-Lite control slave, streamed samples, argmax output.
module zy_net #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FRAC_BITS   = 12,
  parameter int unsigned NUM_INPUTS  = 784,
  parameter int unsigned NUM_NEURONS = 10
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  input  logic [31:0]           s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [31:0]           s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [DATA_WIDTH-1:0] axis_in_data,
  input  logic                  axis_in_data_valid,
  output logic                  axis_in_data_ready,
  output logic                  intr
);
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = 2 * DW + 10;
  localparam int unsigned IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned CW = $clog2(NUM_INPUTS + 1);
  localparam int unsigned NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic signed [AW-1:0] YMAX = {{(AW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};

  typedef enum logic [2:0] {StIdle, StAccum, StBias, StArgmax, StDone} state_e;

  logic signed [DW-1:0] weight_mem [NUM_NEURONS][NUM_INPUTS];
  logic signed [DW-1:0] bias_mem   [NUM_NEURONS];

  logic          aw_ready_q, b_valid_q, ar_ready_q, r_valid_q;
  logic [31:0]   r_data_q, rd_mux;
  logic [31:0]   layer_q, neuron_q;
  logic          soft_rst_q;
  logic [IW-1:0] waddr_q;

  state_e               state_q;
  logic [CW-1:0]        icnt_q;
  logic [NW-1:0]        am_cnt_q, best_idx_q, result_q, optr_q;
  logic signed [DW-1:0] best_val_q;
  logic                 intr_q;
  logic signed [AW-1:0] acc_q  [NUM_NEURONS];
  logic signed [DW-1:0] y_q    [NUM_NEURONS];
  logic signed [2*DW-1:0] prod [NUM_NEURONS];
  logic signed [AW-1:0] prod_ext [NUM_NEURONS];

  logic                 wr_en, rd_en, commit_ok, wt_we, bias_we, rd_result, rd_out;
  logic                 busy, accept;
  logic [4:0]           wr_addr, rd_addr;
  logic [IW-1:0]        widx;
  logic signed [DW-1:0] sample;

  assign wr_en     = aw_ready_q & s_axi_awvalid & s_axi_wvalid;
  assign rd_en     = ar_ready_q & s_axi_arvalid;
  assign wr_addr   = s_axi_awaddr[4:0];
  assign rd_addr   = s_axi_araddr[4:0];
  assign commit_ok = (layer_q == 32'd1) && (neuron_q < NUM_NEURONS);
  assign wt_we     = wr_en && (wr_addr == 5'h00) && commit_ok;
  assign bias_we   = wr_en && (wr_addr == 5'h04) && commit_ok;
  assign rd_result = rd_en && (rd_addr == 5'h08);
  assign rd_out    = rd_en && (rd_addr == 5'h14);

  assign s_axi_awready = aw_ready_q;
  assign s_axi_wready  = aw_ready_q;
  assign s_axi_bvalid  = b_valid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = ar_ready_q;
  assign s_axi_rvalid  = r_valid_q;
  assign s_axi_rdata   = r_data_q;
  assign s_axi_rresp   = 2'b00;

  assign busy               = (state_q != StIdle);
  assign axis_in_data_ready = ((state_q == StIdle) || (state_q == StAccum)) && !soft_rst_q;
  assign accept             = axis_in_data_valid & axis_in_data_ready;
  assign intr               = intr_q;
  assign sample             = axis_in_data;
  // A new run always starts from weight column 0, whatever icnt holds from the last run.
  assign widx               = (state_q == StAccum) ? icnt_q[IW-1:0] : '0;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr[31:5], s_axi_araddr[31:5], s_axi_awprot, s_axi_arprot,
                       s_axi_wstrb};

  function automatic logic signed [2*DW-1:0] sext2(input logic signed [DW-1:0] v);
    return {{DW{v[DW-1]}}, v};
  endfunction

  function automatic logic signed [DW-1:0] finish_neuron(input logic signed [AW-1:0] acc,
                                                          input logic signed [DW-1:0] b);
    logic signed [AW-1:0] bias_ext;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] shr;
    bias_ext = {{(AW - DW){b[DW-1]}}, b};
    sum      = acc + (bias_ext <<< FRAC_BITS);
    shr      = sum >>> FRAC_BITS;
    if (shr[AW-1]) return '0;
    if (shr > YMAX) return YMAX[DW-1:0];
    return shr[DW-1:0];
  endfunction

  always_comb begin
    for (int n = 0; n < NUM_NEURONS; n++) begin
      prod[n]     = sext2(sample) * sext2(weight_mem[n][widx]);
      prod_ext[n] = {{(AW - 2 * DW){prod[n][2*DW-1]}}, prod[n]};
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      5'h08:   rd_mux = 32'(result_q);
      5'h0C:   rd_mux = layer_q;
      5'h10:   rd_mux = neuron_q;
      5'h14:   rd_mux = {{(32 - DW){y_q[optr_q][DW-1]}}, y_q[optr_q]};
      5'h18:   rd_mux = {29'b0, soft_rst_q, intr_q, busy};
      5'h1C:   rd_mux = {31'b0, soft_rst_q};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      aw_ready_q <= 1'b0;
      b_valid_q  <= 1'b0;
      layer_q    <= '0;
      neuron_q   <= '0;
      soft_rst_q <= 1'b1;
      waddr_q    <= '0;
    end else begin
      aw_ready_q <= s_axi_awvalid & s_axi_wvalid & ~b_valid_q & ~aw_ready_q;
      if (wr_en) b_valid_q <= 1'b1;
      else if (s_axi_bready) b_valid_q <= 1'b0;
      if (wr_en) begin
        case (wr_addr)
          5'h00: if (commit_ok) waddr_q <= (waddr_q == IW'(NUM_INPUTS - 1)) ? '0 : waddr_q + 1'b1;
          5'h0C: begin
            layer_q <= s_axi_wdata;
            waddr_q <= '0;
          end
          5'h10: begin
            neuron_q <= s_axi_wdata;
            waddr_q  <= '0;
          end
          5'h1C:   soft_rst_q <= s_axi_wdata[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
    end else begin
      ar_ready_q <= s_axi_arvalid & ~r_valid_q & ~ar_ready_q;
      if (rd_en) begin
        r_valid_q <= 1'b1;
        r_data_q  <= rd_mux;
      end else if (s_axi_rready) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  // RAMs carry no reset; they keep their contents across both resets and are loaded over AXI.
  always_ff @(posedge s_axi_aclk) begin
    if (wt_we)   weight_mem[neuron_q[NW-1:0]][waddr_q] <= s_axi_wdata[DW-1:0];
    if (bias_we) bias_mem[neuron_q[NW-1:0]] <= s_axi_wdata[DW-1:0];
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q    <= StIdle;
      icnt_q     <= '0;
      am_cnt_q   <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      result_q   <= '0;
      optr_q     <= '0;
      intr_q     <= 1'b0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        acc_q[n] <= '0;
        y_q[n]   <= '0;
      end
    end else if (soft_rst_q) begin
      state_q  <= StIdle;
      icnt_q   <= '0;
      am_cnt_q <= '0;
      optr_q   <= '0;
      intr_q   <= 1'b0;
    end else begin
      if (rd_out) optr_q <= (optr_q == NW'(NUM_NEURONS - 1)) ? '0 : optr_q + 1'b1;
      if (rd_result) intr_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            for (int n = 0; n < NUM_NEURONS; n++) acc_q[n] <= prod_ext[n];
            icnt_q  <= CW'(1);
            intr_q  <= 1'b0;
            state_q <= (NUM_INPUTS == 1) ? StBias : StAccum;
          end
        end
        StAccum: begin
          if (accept) begin
            for (int n = 0; n < NUM_NEURONS; n++) acc_q[n] <= acc_q[n] + prod_ext[n];
            icnt_q <= icnt_q + 1'b1;
            if (icnt_q == CW'(NUM_INPUTS - 1)) state_q <= StBias;
          end
        end
        StBias: begin
          for (int n = 0; n < NUM_NEURONS; n++) y_q[n] <= finish_neuron(acc_q[n], bias_mem[n]);
          am_cnt_q   <= '0;
          best_val_q <= '0;
          best_idx_q <= '0;
          state_q    <= StArgmax;
        end
        StArgmax: begin
          // Outputs are non-negative, so starting from (0, index 0) gives index 0 on all-zero.
          if (y_q[am_cnt_q] > best_val_q) begin
            best_val_q <= y_q[am_cnt_q];
            best_idx_q <= am_cnt_q;
          end
          if (am_cnt_q == NW'(NUM_NEURONS - 1)) state_q <= StDone;
          else am_cnt_q <= am_cnt_q + 1'b1;
        end
        StDone: begin
          result_q <= best_idx_q;
          intr_q   <= 1'b1;
          optr_q   <= '0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_zy_net.sv
// Directed self-checking bench for zy_net: AXI-Lite register access, streamed classification runs,
// scoreboard of expected results/outputs computed from a shadow model of the weight/bias RAMs.
module tb_zy_net;
  localparam int NI  = 784;
  localparam int NN  = 10;
  localparam int LIM = 100;

  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [15:0] sdata;
  logic        svalid, sready, intr;

  zy_net dut (
    .s_axi_aclk        (clk),
    .s_axi_areset      (areset),
    .s_axi_awaddr      (awaddr),
    .s_axi_awprot      (awprot),
    .s_axi_awvalid     (awvalid),
    .s_axi_awready     (awready),
    .s_axi_wdata       (wdata),
    .s_axi_wstrb       (wstrb),
    .s_axi_wvalid      (wvalid),
    .s_axi_wready      (wready),
    .s_axi_bresp       (bresp),
    .s_axi_bvalid      (bvalid),
    .s_axi_bready      (bready),
    .s_axi_araddr      (araddr),
    .s_axi_arprot      (arprot),
    .s_axi_arvalid     (arvalid),
    .s_axi_arready     (arready),
    .s_axi_rdata       (rdata),
    .s_axi_rresp       (rresp),
    .s_axi_rvalid      (rvalid),
    .s_axi_rready      (rready),
    .axis_in_data      (sdata),
    .axis_in_data_valid(svalid),
    .axis_in_data_ready(sready),
    .intr              (intr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int timeouts = 0;

  shortint mw [NN][NI];
  shortint mb [NN];
  int m_layer = 0, m_neuron = 0, m_waddr = 0;

  int          exp_res_q[$];
  logic [31:0] exp_y_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    int t = 0;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!awready && t < LIM) begin tick(); t++; end
    if (t >= LIM) timeouts++;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    while (!bvalid && t < LIM) begin tick(); t++; end
    if (t >= LIM) timeouts++;
    tick();
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    int t = 0;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    while (!arready && t < LIM) begin tick(); t++; end
    if (t >= LIM) timeouts++;
    tick();
    arvalid = 1'b0;
    while (!rvalid && t < LIM) begin tick(); t++; end
    if (t >= LIM) timeouts++;
    data = rdata;
    tick();
  endtask

  task automatic set_layer(input int v);
    axi_write(32'h0C, 32'(v)); m_layer = v; m_waddr = 0;
  endtask

  task automatic set_neuron(input int v);
    axi_write(32'h10, 32'(v)); m_neuron = v; m_waddr = 0;
  endtask

  task automatic wr_w(input logic [15:0] v);
    axi_write(32'h00, {16'h0, v});
    if (m_layer == 1 && m_neuron < NN) begin
      mw[m_neuron][m_waddr] = shortint'(v);
      m_waddr = (m_waddr + 1) % NI;
    end
  endtask

  task automatic wr_b(input logic [15:0] v);
    axi_write(32'h04, {16'h0, v});
    if (m_layer == 1 && m_neuron < NN) mb[m_neuron] = shortint'(v);
  endtask

  // Expected outputs for a run in which every sample equals x.
  task automatic push_expect(input int x);
    longint acc, y, bestv;
    int best;
    best = 0; bestv = 0;
    for (int n = 0; n < NN; n++) begin
      acc = 0;
      for (int i = 0; i < NI; i++) acc += longint'(x) * longint'(mw[n][i]);
      y = (acc + longint'(mb[n]) * 4096) >>> 12;
      if (y > 32767) y = 32767;
      if (y < 0) y = 0;
      exp_y_q.push_back(32'(y));
      if (y > bestv) begin bestv = y; best = n; end
    end
    exp_res_q.push_back(best);
  endtask

  task automatic stream(input int n, input logic [15:0] x, input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin svalid = 1'b0; tick(); end
      sdata = x; svalid = 1'b1;
      t = 0;
      while (!sready && t < LIM) begin tick(); t++; end
      if (t >= LIM) begin timeouts++; break; end
      tick();
    end
    svalid = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    int t = 0;
    logic [31:0] d;
    int r;
    while (!intr && t < 200) begin tick(); t++; end
    check({tag, "_intr_set"}, {31'b0, intr}, 32'd1);
    axi_read(32'h08, d);
    r = (exp_res_q.size() > 0) ? exp_res_q.pop_front() : -1;
    check({tag, "_result"}, d, 32'(r));
    check({tag, "_intr_clr"}, {31'b0, intr}, 32'd0);
    for (int n = 0; n < NN; n++) begin
      axi_read(32'h14, d);
      check($sformatf("%s_y%0d", tag, n), d, (exp_y_q.size() > 0) ? exp_y_q.pop_front() : 'x);
    end
    axi_read(32'h18, d);
    check({tag, "_status"}, d, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int t;
    areset = 1'b1; awaddr = '0; wdata = '0; araddr = '0; awprot = '0; arprot = '0;
    wstrb = 4'hF; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0;
    rready = 1'b0; sdata = '0; svalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;

    // Reset state
    check("rst_intr", {31'b0, intr}, 32'd0);
    check("rst_ready", {31'b0, sready}, 32'd0);
    check("rst_awready", {31'b0, awready}, 32'd0);
    check("rst_bvalid", {31'b0, bvalid}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    axi_read(32'h18, d); check("rst_status", d, 32'h4);
    axi_read(32'h1C, d); check("rst_softrst", d, 32'h1);
    axi_read(32'h0C, d); check("rst_layer", d, 32'h0);
    axi_read(32'h10, d); check("rst_neuron", d, 32'h0);
    axi_read(32'h08, d); check("rst_result", d, 32'h0);

    axi_write(32'h1C, 32'h0);
    axi_read(32'h18, d); check("run_status", d, 32'h0);
    check("run_ready", {31'b0, sready}, 32'd1);

    // Load: neuron 3 weights = 1.0, every bias 0
    set_layer(1);
    for (int n = 0; n < NN; n++) begin set_neuron(n); wr_b(16'h0000); end
    set_neuron(3);
    for (int i = 0; i < NI; i++) wr_w(16'h1000);
    axi_read(32'h10, d); check("neuron_rb", d, 32'h3);
    axi_read(32'h0C, d); check("layer_rb", d, 32'h1);
    axi_write(32'h18, 32'hFFFF_FFFF);
    axi_read(32'h04, d); check("unmapped_rd04", d, 32'h0);
    axi_read(32'h18, d); check("ro_status", d, 32'h0);

    push_expect(256);
    stream(NI, 16'h0100, 1'b0);
    finish_run("run1");

    // Bias tie and negative bias; zero samples null out every weight
    set_neuron(7); wr_b(16'h0800);
    set_neuron(2); wr_b(16'h0800);
    set_neuron(5); wr_b(16'hF000);
    push_expect(0);
    stream(NI, 16'h0000, 1'b0);
    finish_run("bias");

    // Gated writes: LAYER!=1, then NEURON out of range
    set_layer(2); set_neuron(2);
    for (int i = 0; i < 5; i++) wr_w(16'h7FFF);
    wr_b(16'h7FFF);
    set_layer(1); set_neuron(12);
    for (int i = 0; i < 3; i++) wr_w(16'h7FFF);
    wr_b(16'h7FFF);
    push_expect(256);
    stream(NI, 16'h0100, 1'b0);
    finish_run("gated");

    // Committed writes to neuron 1, then an aborted partial run
    set_neuron(1);
    wr_w(16'h7FFF); wr_w(16'h7FFF); wr_b(16'h7FFF);
    stream(400, 16'h0010, 1'b0);
    axi_read(32'h18, d); check("abort_busy", d, 32'h1);
    axi_write(32'h1C, 32'h1);
    axi_read(32'h18, d); check("abort_soft", d, 32'h4);
    axi_write(32'h1C, 32'h0);
    repeat (20) tick();
    check("abort_no_intr", {31'b0, intr}, 32'd0);
    axi_read(32'h18, d); check("abort_idle", d, 32'h0);
    push_expect(16);
    stream(NI, 16'h0010, 1'b0);
    finish_run("full");
    repeat (30) tick();
    check("single_intr", {31'b0, intr}, 32'd0);

    push_expect(16);
    stream(NI, 16'h0010, 1'b1);
    finish_run("gapped");

    // Back-to-back writes with bready held low
    awaddr = 32'h0C; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    t = 0;
    while (!awready && t < LIM) begin tick(); t++; end
    if (t >= LIM) timeouts++;
    tick();
    awaddr = 32'h10; wdata = 32'h4;
    for (int i = 0; i < 4; i++) begin
      check("b_hold", {31'b0, bvalid}, 32'd1);
      check("aw_block", {31'b0, awready}, 32'd0);
      tick();
    end
    bready = 1'b1;
    tick();
    t = 0;
    while (!awready && t < LIM) begin tick(); t++; end
    if (t >= LIM) timeouts++;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("b_second", {31'b0, bvalid}, 32'd1);
    tick();
    check("b_done", {31'b0, bvalid}, 32'd0);
    axi_read(32'h10, d); check("b2b_neuron", d, 32'h4);

    check("timeouts", 32'(timeouts), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
